// File: rtl/axis_rr_arbiter.sv
// Two-input AXI-Stream packet arbiter with round-robin tie-break and a per-packet beat limit.
// Output beat is registered; an over-long packet is cut at MAX_BEATS and trunc pulses.
module axis_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic              s0_last,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic              s1_last,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [1:0]        grant,
  output logic              trunc
);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_e;

  localparam logic [7:0] CNT_MAX = 8'(MAX_BEATS - 1);

  state_e            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [7:0]        beat_q, beat_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              trunc_q, trunc_d;
  logic [1:0]        rst_sync_q;
  logic              run;

  logic              out_free, xfer0, xfer1, xfer, sel_last, cnt_hit, term;
  logic [DATA_W-1:0] sel_data;

  // Reset asserts asynchronously but releases two edges later, so logic never leaves reset mid-edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign run = rst_sync_q[1];

  assign out_free = !m_valid_q || m_ready;
  assign s0_ready = (state_q == G0) && out_free;
  assign s1_ready = (state_q == G1) && out_free;
  assign grant    = {state_q == G1, state_q == G0};

  assign xfer0    = s0_valid && s0_ready;
  assign xfer1    = s1_valid && s1_ready;
  assign xfer     = xfer0 || xfer1;
  assign sel_data = xfer1 ? s1_data : s0_data;
  assign sel_last = xfer1 ? s1_last : s0_last;
  assign cnt_hit  = (beat_q == CNT_MAX);
  assign term     = xfer && (sel_last || cnt_hit);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_d       = beat_q;
    case (state_q)
      IDLE: begin
        // On a tie the port that did not own the previous packet wins.
        if (s0_valid && (!s1_valid || last_owner_q)) begin
          state_d      = G0;
          last_owner_d = 1'b0;
          beat_d       = '0;
        end else if (s1_valid) begin
          state_d      = G1;
          last_owner_d = 1'b1;
          beat_d       = '0;
        end
      end
      G0, G1: begin
        if (xfer) beat_d = beat_q + 8'd1;
        if (term) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    trunc_d   = term && !sel_last;
    if (xfer) begin
      m_data_d  = sel_data;
      m_valid_d = 1'b1;
      m_last_d  = term;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      beat_q       <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      trunc_q      <= 1'b0;
    end else if (run) begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_q       <= beat_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      trunc_q      <= trunc_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign trunc   = trunc_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-scenario tasks with hand-computed cycle expectations.
module tb_axis_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] s0_data = '0, s1_data = '0, m_data;
  logic       s0_valid = 1'b0, s0_ready, s0_last = 1'b0;
  logic       s1_valid = 1'b0, s1_ready, s1_last = 1'b0;
  logic       m_valid, m_ready = 1'b1, m_last, trunc;
  logic [1:0] grant;

  axis_rr_arbiter #(.DATA_W(8), .MAX_BEATS(16)) dut (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_last(s0_last),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_last(s1_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .grant(grant), .trunc(trunc)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] d; logic l;} beat_t;
  beat_t      q0[$], q1[$];
  logic       mr_pat[$];
  logic       lv[$], ll[$], lt[$], r0[$], r1[$];
  logic [7:0] ld[$];
  logic [1:0] lg[$];
  int         n_chk = 0, n_fail = 0;

  task automatic add_pkt(input int port, input logic [7:0] base, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = base + 8'(i);
      b.l = (i == len - 1);
      if (port == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  // Each cycle: present queue heads, sample ready before the edge, log outputs 1 time unit after it.
  task automatic run(input int n);
    logic  h0, h1;
    beat_t tmp;
    lv.delete(); ll.delete(); lt.delete(); ld.delete(); lg.delete(); r0.delete(); r1.delete();
    for (int k = 0; k < n; k++) begin
      s0_valid = (q0.size() > 0);
      s0_data  = s0_valid ? q0[0].d : 8'h00;
      s0_last  = s0_valid ? q0[0].l : 1'b0;
      s1_valid = (q1.size() > 0);
      s1_data  = s1_valid ? q1[0].d : 8'h00;
      s1_last  = s1_valid ? q1[0].l : 1'b0;
      m_ready  = (mr_pat.size() > 0) ? mr_pat.pop_front() : 1'b1;
      #1;
      h0 = s0_valid && s0_ready;
      h1 = s1_valid && s1_ready;
      r0.push_back(s0_ready);
      r1.push_back(s1_ready);
      @(posedge clk);
      #1;
      if (h0) tmp = q0.pop_front();
      if (h1) tmp = q1.pop_front();
      lv.push_back(m_valid); ll.push_back(m_last); lt.push_back(trunc);
      ld.push_back(m_data);  lg.push_back(grant);
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
  endtask

  task automatic test_reset;
    s0_valid = 1'b1; s1_valid = 1'b1; s0_data = 8'h5A; s1_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant got=%b exp=00", grant); end
    n_chk++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b%b exp=00", s0_ready, s1_ready); end
    n_chk++; if (m_valid !== 1'b0 || m_last !== 1'b0 || trunc !== 1'b0) begin n_fail++; $display("FAIL rst_flags got v=%b l=%b t=%b exp 0", m_valid, m_last, trunc); end
    n_chk++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got=%h exp=00", m_data); end
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic test_tie_after_reset;
    logic [7:0] ed[6];
    logic       el[6];
    int         j;
    ed = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
    el = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    add_pkt(0, 8'hA0, 3);
    add_pkt(1, 8'hB0, 3);
    rst = 1'b1;
    run(12);
    n_chk++; if (lg[0] !== 2'b00 || lg[1] !== 2'b00) begin n_fail++; $display("FAIL tie_sync got=%b,%b exp=00,00", lg[0], lg[1]); end
    n_chk++; if (lg[2] !== 2'b01) begin n_fail++; $display("FAIL tie_grant0 got=%b exp=01", lg[2]); end
    n_chk++; if (lv[3] !== 1'b1 || ld[3] !== 8'hA0) begin n_fail++; $display("FAIL tie_latency got v=%b d=%h exp v=1 d=a0", lv[3], ld[3]); end
    n_chk++; if (lv[6] !== 1'b0) begin n_fail++; $display("FAIL tie_bubble got=%b exp=0", lv[6]); end
    n_chk++; if (lg[6] !== 2'b10) begin n_fail++; $display("FAIL tie_grant1 got=%b exp=10", lg[6]); end
    j = 0;
    for (int k = 0; k < 12; k++) begin
      if (lv[k] === 1'b1) begin
        if (j < 6) begin
          n_chk++;
          if (ld[k] !== ed[j] || ll[k] !== el[j]) begin
            n_fail++; $display("FAIL tie_beat%0d got d=%h l=%b exp d=%h l=%b", j, ld[k], ll[k], ed[j], el[j]);
          end
        end
        j++;
      end
    end
    n_chk++; if (j != 6) begin n_fail++; $display("FAIL tie_count got=%0d exp=6", j); end
  endtask

  task automatic test_backpressure;
    add_pkt(0, 8'hC0, 2);
    mr_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    run(8);
    n_chk++; if (lg[0] !== 2'b01) begin n_fail++; $display("FAIL bp_grant got=%b exp=01", lg[0]); end
    for (int k = 2; k <= 4; k++) begin
      n_chk++; if (r0[k] !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d got=%b exp=0", k, r0[k]); end
      n_chk++; if (lv[k] !== 1'b1 || ld[k] !== 8'hC0 || ll[k] !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d got v=%b d=%h l=%b exp v=1 d=c0 l=0", k, lv[k], ld[k], ll[k]);
      end
    end
    n_chk++; if (r0[5] !== 1'b1) begin n_fail++; $display("FAIL bp_resume_ready got=%b exp=1", r0[5]); end
    n_chk++; if (lv[5] !== 1'b1 || ld[5] !== 8'hC1 || ll[5] !== 1'b1) begin
      n_fail++; $display("FAIL bp_beat2 got v=%b d=%h l=%b exp v=1 d=c1 l=1", lv[5], ld[5], ll[5]);
    end
  endtask

  task automatic test_trunc;
    int nt, nl, nv;
    // Last flag coinciding with the beat limit ends the packet cleanly.
    add_pkt(0, 8'h60, 16);
    run(20);
    nt = 0; nl = 0;
    for (int k = 0; k < 20; k++) begin nt += int'(lt[k]); nl += int'(ll[k]); end
    n_chk++; if (nt != 0) begin n_fail++; $display("FAIL coincide_trunc got=%0d exp=0", nt); end
    n_chk++; if (lv[16] !== 1'b1 || ll[16] !== 1'b1 || ld[16] !== 8'h6F) begin
      n_fail++; $display("FAIL coincide_last got v=%b l=%b d=%h exp v=1 l=1 d=6f", lv[16], ll[16], ld[16]);
    end
    n_chk++; if (nl != 1) begin n_fail++; $display("FAIL coincide_nlast got=%0d exp=1", nl); end
    add_pkt(1, 8'h40, 20);
    run(26);
    nt = 0; nl = 0; nv = 0;
    for (int k = 0; k < 26; k++) begin nt += int'(lt[k]); nl += int'(ll[k]); nv += int'(lv[k]); end
    n_chk++; if (ll[16] !== 1'b1 || ld[16] !== 8'h4F || lt[16] !== 1'b1) begin
      n_fail++; $display("FAIL trunc_cut got l=%b d=%h t=%b exp l=1 d=4f t=1", ll[16], ld[16], lt[16]);
    end
    n_chk++; if (nt != 1) begin n_fail++; $display("FAIL trunc_pulses got=%0d exp=1", nt); end
    n_chk++; if (lv[17] !== 1'b0) begin n_fail++; $display("FAIL trunc_bubble got=%b exp=0", lv[17]); end
    n_chk++; if (lv[21] !== 1'b1 || ld[21] !== 8'h53 || ll[21] !== 1'b1 || lt[21] !== 1'b0) begin
      n_fail++; $display("FAIL trunc_tail got v=%b d=%h l=%b t=%b exp v=1 d=53 l=1 t=0", lv[21], ld[21], ll[21], lt[21]);
    end
    n_chk++; if (nv != 20 || nl != 2) begin n_fail++; $display("FAIL trunc_counts got beats=%0d lasts=%0d exp 20,2", nv, nl); end
  endtask

  task automatic test_alternate;
    logic [7:0] ed[4];
    logic [1:0] eg[4];
    ed = '{8'h10, 8'h20, 8'h11, 8'h21};
    eg = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      add_pkt(0, 8'h10 + 8'(i), 1);
      add_pkt(1, 8'h20 + 8'(i), 1);
    end
    run(18);
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (lg[2*i] !== eg[i]) begin n_fail++; $display("FAIL alt_grant%0d got=%b exp=%b", i, lg[2*i], eg[i]); end
      n_chk++; if (lv[2*i+1] !== 1'b1 || ld[2*i+1] !== ed[i] || ll[2*i+1] !== 1'b1) begin
        n_fail++; $display("FAIL alt_beat%0d got v=%b d=%h l=%b exp v=1 d=%h l=1", i, lv[2*i+1], ld[2*i+1], ll[2*i+1], ed[i]);
      end
    end
    n_chk++; if (lv[2] !== 1'b0 || lv[4] !== 1'b0) begin n_fail++; $display("FAIL alt_gap got=%b%b exp=00", lv[2], lv[4]); end
  endtask

  task automatic test_reset_mid_packet;
    add_pkt(0, 8'h30, 4);
    run(3);
    n_chk++; if (lv[2] !== 1'b1 || ld[2] !== 8'h31) begin n_fail++; $display("FAIL rmid_beat2 got v=%b d=%h exp v=1 d=31", lv[2], ld[2]); end
    s0_valid = 1'b1;
    rst = 1'b0;
    #2;
    n_chk++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got v=%b l=%b exp 0", m_valid, m_last); end
    n_chk++; if (grant !== 2'b00 || s0_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_grant got g=%b r=%b exp g=00 r=0", grant, s0_ready); end
    q0.delete();
    s0_valid = 1'b0;
    @(posedge clk);
    #1;
    add_pkt(1, 8'h55, 1);
    rst = 1'b1;
    run(6);
    n_chk++; if (lv[0] !== 1'b0 || lv[1] !== 1'b0 || lv[2] !== 1'b0) begin n_fail++; $display("FAIL rmid_nopartial got=%b%b%b exp=000", lv[0], lv[1], lv[2]); end
    n_chk++; if (lg[2] !== 2'b10) begin n_fail++; $display("FAIL rmid_regrant got=%b exp=10", lg[2]); end
    n_chk++; if (lv[3] !== 1'b1 || ld[3] !== 8'h55 || ll[3] !== 1'b1) begin
      n_fail++; $display("FAIL rmid_p1beat got v=%b d=%h l=%b exp v=1 d=55 l=1", lv[3], ld[3], ll[3]);
    end
  endtask

  task automatic test_hold_off;
    add_pkt(0, 8'h70, 3);
    add_pkt(1, 8'h80, 1);
    run(8);
    n_chk++; if (lg[0] !== 2'b01) begin n_fail++; $display("FAIL hold_grant0 got=%b exp=01", lg[0]); end
    for (int k = 0; k <= 4; k++) begin
      n_chk++; if (r1[k] !== 1'b0) begin n_fail++; $display("FAIL hold_ready%0d got=%b exp=0", k, r1[k]); end
    end
    n_chk++; if (lg[4] !== 2'b10 || r1[5] !== 1'b1) begin n_fail++; $display("FAIL hold_release got g=%b r=%b exp g=10 r=1", lg[4], r1[5]); end
    n_chk++; if (ld[5] !== 8'h80 || ll[5] !== 1'b1) begin n_fail++; $display("FAIL hold_beat got d=%h l=%b exp d=80 l=1", ld[5], ll[5]); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset;
    test_tie_after_reset;
    test_backpressure;
    test_trunc;
    test_alternate;
    test_reset_mid_packet;
    test_hold_off;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
